// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared defaults and sizing helper
// for the switch debouncer slice.
package sw_debounce_pkg;

  localparam int NUM_SW_DEFAULT          = 8;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

  // Bits needed to hold any value in 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: one switch lane -- 2-flop synchronizer,
// stability counter and debounced output flop.
//
// Ports:
//   clk    - clock, all state on rising edge
//   rst_n  - async active-low reset
//   i_raw  - asynchronous switch level
//   o_sw   - debounced level
//   o_upd  - high in the cycle before o_sw flips
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_sw,
  output logic o_upd
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_sw;

  logic w_diff;
  logic w_last;

  assign w_diff = r_sync2 ^ r_sw;
  assign w_last = (r_cnt == CNT_LAST);

  // Asserted when this edge will load the new level,
  // so the top can register the change alongside o_sw.
  assign o_upd = w_diff & w_last;
  assign o_sw  = r_sw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_sw    <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_last) begin
        r_cnt <= '0;
        r_sw  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: debounces NUM_SW board switches and
// reports changes once the post-reset window has passed.
//
// Ports:
//   clk            - clock, all state on rising edge
//   rst_n          - async active-low reset
//   sw_raw         - raw switch levels (bit0 = A)
//   sw             - debounced switch levels
//   sw_changed     - one-cycle pulse when sw changes
//   sw_change_mask - bits of sw that changed
//   ready          - initial settling window done
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int NUM_SW          = NUM_SW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] sw,
  output logic              sw_changed,
  output logic [NUM_SW-1:0] sw_change_mask,
  output logic              ready
);

  localparam int IW = cnt_width(DEBOUNCE_CYCLES + 2);
  localparam logic [IW-1:0] INIT_LAST =
    IW'(DEBOUNCE_CYCLES + 1);

  logic [NUM_SW-1:0] w_upd;
  logic [IW-1:0]     r_init_cnt;
  logic              r_ready;
  logic              r_changed;
  logic [NUM_SW-1:0] r_mask;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .i_raw(sw_raw[g]),
      .o_sw (sw[g]),
      .o_upd(w_upd[g])
    );
  end

  // Counts to 2+DEBOUNCE_CYCLES then freezes; the
  // increment is gated by r_ready so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_cnt <= '0;
      r_ready    <= 1'b0;
    end else if (!r_ready) begin
      r_init_cnt <= r_init_cnt + 1'b1;
      if (r_init_cnt == INIT_LAST) begin
        r_ready <= 1'b1;
      end
    end
  end

  // Gated by the pre-edge ready, so updates landing on
  // the ready edge itself are still suppressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_changed <= 1'b0;
      r_mask    <= '0;
    end else begin
      r_changed <= r_ready & (|w_upd);
      r_mask    <= r_ready ? w_upd : '0;
    end
  end

  assign sw_changed     = r_changed;
  assign sw_change_mask = r_mask;
  assign ready          = r_ready;

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed vector bench for sw_debounce
// with DEBOUNCE_CYCLES=4 and eight switches.
module tb_sw_debounce;

  localparam int D = 4;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] sw_raw = '0;
  logic [N-1:0] sw;
  logic         sw_changed;
  logic [N-1:0] sw_change_mask;
  logic         ready;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0] raw;
    int         edges;
    logic [7:0] exp_sw;
    int         exp_pulses;
    logic [7:0] exp_mask;
  } vec_t;

  vec_t vecs [11];

  sw_debounce #(
    .DEBOUNCE_CYCLES(D),
    .NUM_SW(N)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sw_raw        (sw_raw),
    .sw            (sw),
    .sw_changed    (sw_changed),
    .sw_change_mask(sw_change_mask),
    .ready         (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int edges,
                     output int pulses,
                     output logic [7:0] mask,
                     output int bad);
    pulses = 0;
    mask   = '0;
    bad    = 0;
    for (int i = 0; i < edges; i++) begin
      tick();
      if (sw_changed) begin
        pulses++;
        mask |= sw_change_mask;
      end else if (sw_change_mask != '0) begin
        bad++;
      end
    end
  endtask

  // Released just after an edge: edge 6 must show
  // both the settled sw and ready, with no pulse ever.
  task automatic release_check(input logic [7:0] exp_sw,
                               input string tag);
    int pulses;
    logic [7:0] m;
    int bad;
    pulses = 0;
    rst_n = 1'b1;
    for (int e = 1; e <= 2 + D; e++) begin
      tick();
      if (sw_changed) pulses++;
      if (e == 1 + D) begin
        chk({tag, " ready e5"}, 32'(ready), 32'd0);
        chk({tag, " sw e5"}, 32'(sw), 32'h00);
      end
      if (e == 2 + D) begin
        chk({tag, " ready e6"}, 32'(ready), 32'd1);
        chk({tag, " sw e6"}, 32'(sw), 32'(exp_sw));
      end
    end
    run(3, bad, m, bad);
    chk({tag, " no pulse"}, 32'(pulses + bad), 32'd0);
    chk({tag, " sw hold"}, 32'(sw), 32'(exp_sw));
  endtask

  initial begin
    int p;
    logic [7:0] m;
    int bad;

    vecs[0]  = '{8'h81, 3,  8'h80, 0, 8'h00};
    vecs[1]  = '{8'h80, 8,  8'h80, 0, 8'h00};
    vecs[2]  = '{8'h81, 10, 8'h81, 1, 8'h01};
    vecs[3]  = '{8'h80, 10, 8'h80, 1, 8'h01};
    vecs[4]  = '{8'h9B, 10, 8'h9B, 1, 8'h1B};
    vecs[5]  = '{8'h00, 10, 8'h00, 1, 8'h9B};
    vecs[6]  = '{8'hFF, 10, 8'hFF, 1, 8'hFF};
    vecs[7]  = '{8'hAA, 10, 8'hAA, 1, 8'h55};
    vecs[8]  = '{8'hAA, 5,  8'hAA, 0, 8'h00};
    vecs[9]  = '{8'hAB, 1,  8'hAA, 0, 8'h00};
    vecs[10] = '{8'hAA, 8,  8'hAA, 0, 8'h00};

    // Reset state before any clock edge.
    #2;
    chk("rst sw", 32'(sw), 32'h00);
    chk("rst changed", 32'(sw_changed), 32'd0);
    chk("rst mask", 32'(sw_change_mask), 32'h00);
    chk("rst ready", 32'(ready), 32'd0);
    tick();
    tick();
    release_check(8'h00, "init");

    // Exact latency of a clean step.
    sw_raw = 8'h80;
    for (int e = 1; e <= 2 + D; e++) begin
      tick();
      if (e == 1 + D) begin
        chk("step sw e5", 32'(sw), 32'h00);
        chk("step chg e5", 32'(sw_changed), 32'd0);
      end
      if (e == 2 + D) begin
        chk("step sw e6", 32'(sw), 32'h80);
        chk("step chg e6", 32'(sw_changed), 32'd1);
        chk("step mask e6", 32'(sw_change_mask), 32'h80);
      end
    end
    tick();
    chk("step chg e7", 32'(sw_changed), 32'd0);
    chk("step mask e7", 32'(sw_change_mask), 32'h00);

    for (int i = 0; i < 11; i++) begin
      sw_raw = vecs[i].raw;
      run(vecs[i].edges, p, m, bad);
      chk($sformatf("vec%0d sw", i),
          32'(sw), 32'(vecs[i].exp_sw));
      chk($sformatf("vec%0d pulses", i),
          32'(p), 32'(vecs[i].exp_pulses));
      chk($sformatf("vec%0d mask", i),
          32'(m), 32'(vecs[i].exp_mask));
      chk($sformatf("vec%0d idle mask", i),
          32'(bad), 32'd0);
    end

    // Reset while bit 0 is two counts into its window.
    sw_raw = 8'hAB;
    for (int e = 0; e < 4; e++) tick();
    chk("mid sw pre", 32'(sw), 32'hAA);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid sw", 32'(sw), 32'h00);
    chk("mid changed", 32'(sw_changed), 32'd0);
    chk("mid mask", 32'(sw_change_mask), 32'h00);
    chk("mid ready", 32'(ready), 32'd0);
    tick();
    release_check(8'hAB, "mid");

    // Reset with every switch already on.
    rst_n  = 1'b0;
    sw_raw = 8'hFF;
    tick();
    tick();
    release_check(8'hFF, "allon");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
